rf_write_arbiter: RTL and testbench

Shares the register file's single write port (we3/write_addr/wd3) between the in-order pipeline writeback and the multi-cycle multiply/divide unit (MDU). Pipeline writes have fixed priority. MDU results wait in a 2-entry buffer and drain into idle write slots; a starvation counter forces a drain by stalling the pipeline. A busy scoreboard flags registers with an outstanding MDU result so hazard logic can interlock.

---
 rtl/rf_write_arbiter_if.sv | 33 +++
 rtl/rf_write_arbiter.sv | 135 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the register-file write-port arbitration signals.
// The master drives pipeline and MDU requests. The slave is the arbiter.
interface rf_write_arbiter_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                          pipe_we;
  logic [ADDRESS_WIDTH-1:0]      pipe_addr;
  logic [DATA_WIDTH-1:0]         pipe_wd;
  logic                          mdu_issue;
  logic [ADDRESS_WIDTH-1:0]      mdu_issue_rd;
  logic                          mdu_valid;
  logic [ADDRESS_WIDTH-1:0]      mdu_rd;
  logic [DATA_WIDTH-1:0]         mdu_wd;
  logic                          mdu_ready;
  logic                          pipe_stall;
  logic [2**ADDRESS_WIDTH-1:0]   busy;
  logic                          we3;
  logic [ADDRESS_WIDTH-1:0]      write_addr;
  logic [DATA_WIDTH-1:0]         wd3;

  modport master (
    output pipe_we, pipe_addr, pipe_wd, mdu_issue, mdu_issue_rd,
           mdu_valid, mdu_rd, mdu_wd,
    input  mdu_ready, pipe_stall, busy, we3, write_addr, wd3
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_wd, mdu_issue, mdu_issue_rd,
           mdu_valid, mdu_rd, mdu_wd,
    output mdu_ready, pipe_stall, busy, we3, write_addr, wd3
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority)
// and buffered MDU results, with starvation-forced drains and a busy scoreboard.
module rf_write_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic clk,
  input  logic rst_n,
  rf_write_arbiter_if.slave bus
);
  localparam int NREGS = 2**ADDRESS_WIDTH;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [ADDRESS_WIDTH-1:0] fifo_rd_q [2];
  logic [ADDRESS_WIDTH-1:0] fifo_rd_d [2];
  logic [DATA_WIDTH-1:0]    fifo_wd_q [2];
  logic [DATA_WIDTH-1:0]    fifo_wd_d [2];
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0]               count_q, count_d;
  logic [3:0]               wait_q, wait_d;
  logic                     pipe_stall_q, pipe_stall_d;
  logic [NREGS-1:0]         busy_q, busy_d;
  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

  logic                     pipe_req;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic [ADDRESS_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0]    head_wd;

  assign bus.mdu_ready  = (count_q < 2'd2);
  assign bus.pipe_stall = pipe_stall_q;
  assign bus.busy       = busy_q;
  assign bus.we3        = we3_q;
  assign bus.write_addr = write_addr_q;
  assign bus.wd3        = wd3_q;

  // Pop only looks at entries already counted, so a result accepted this
  // cycle always spends at least one cycle in the buffer.
  always_comb begin
    pipe_req = bus.pipe_we && (bus.pipe_addr != '0);
    accept   = bus.mdu_valid && (count_q < 2'd2);
    push     = accept && (bus.mdu_rd != '0);
    pop      = !pipe_req && (count_q != 2'd0);
    head_rd  = fifo_rd_q[rd_ptr_q];
    head_wd  = fifo_wd_q[rd_ptr_q];

    fifo_rd_d = fifo_rd_q;
    fifo_wd_d = fifo_wd_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push) begin
      fifo_rd_d[wr_ptr_q] = bus.mdu_rd;
      fifo_wd_d[wr_ptr_q] = bus.mdu_wd;
      wr_ptr_d            = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end

    // Saturating wait counter so a very long wait cannot wrap below the limit.
    if ((count_q == 2'd0) || pop) begin
      wait_d = 4'd0;
    end else if (wait_q != 4'hF) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
    pipe_stall_d = (wait_d >= LIMIT);

    busy_d = busy_q;
    if (pop) begin
      busy_d[head_rd] = 1'b0;
    end
    if (bus.mdu_issue && (bus.mdu_issue_rd != '0)) begin
      busy_d[bus.mdu_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    we3_d        = 1'b0;
    write_addr_d = write_addr_q;
    wd3_d        = wd3_q;
    if (pipe_req) begin
      we3_d        = 1'b1;
      write_addr_d = bus.pipe_addr;
      wd3_d        = bus.pipe_wd;
    end else if (pop) begin
      we3_d        = 1'b1;
      write_addr_d = head_rd;
      wd3_d        = head_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_q[0] <= '0;
      fifo_rd_q[1] <= '0;
      fifo_wd_q[0] <= '0;
      fifo_wd_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      wait_q       <= 4'd0;
      pipe_stall_q <= 1'b0;
      busy_q       <= '0;
      we3_q        <= 1'b0;
      write_addr_q <= '0;
      wd3_q        <= '0;
    end else begin
      fifo_rd_q    <= fifo_rd_d;
      fifo_wd_q    <= fifo_wd_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      pipe_stall_q <= pipe_stall_d;
      busy_q       <= busy_d;
      we3_q        <= we3_d;
      write_addr_q <= write_addr_d;
      wd3_q        <= wd3_d;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: linear stimulus steps, with each
// expected value worked out by hand and checked by an immediate assertion.
module tb_rf_write_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rf_write_arbiter_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

  rf_write_arbiter #(
    .ADDRESS_WIDTH(5),
    .DATA_WIDTH(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic pwe, input logic [4:0] paddr,
                               input logic [31:0] pwd, input logic iss,
                               input logic [4:0] iss_rd, input logic mval,
                               input logic [4:0] mrd, input logic [31:0] mwd);
    bus.pipe_we      = pwe;
    bus.pipe_addr    = paddr;
    bus.pipe_wd      = pwd;
    bus.mdu_issue    = iss;
    bus.mdu_issue_rd = iss_rd;
    bus.mdu_valid    = mval;
    bus.mdu_rd       = mrd;
    bus.mdu_wd       = mwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int wr_seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    tick();
    tick();

    checkOutput("reset_we3",        64'(bus.we3),        64'd0);
    checkOutput("reset_write_addr", 64'(bus.write_addr), 64'd0);
    checkOutput("reset_wd3",        64'(bus.wd3),        64'd0);
    checkOutput("reset_stall",      64'(bus.pipe_stall), 64'd0);
    checkOutput("reset_busy",       64'(bus.busy),       64'd0);
    checkOutput("reset_ready",      64'(bus.mdu_ready),  64'd1);
    rst_n = 1'b1;

    $display("[TB] pipeline write to x5");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("pipe_we3",  64'(bus.we3),        64'd1);
    checkOutput("pipe_addr", 64'(bus.write_addr), 64'd5);
    checkOutput("pipe_wd",   64'(bus.wd3),        64'hDEADBEEF);
    idle();
    tick();
    checkOutput("pipe_we3_drop", 64'(bus.we3),        64'd0);
    checkOutput("pipe_addr_hold", 64'(bus.write_addr), 64'd5);

    $display("[TB] x0 writes and discarded MDU result");
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("x0_pipe_we3", 64'(bus.we3), 64'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h99);
    checkOutput("x0_mdu_ready_pre", 64'(bus.mdu_ready), 64'd1);
    tick();
    idle();
    checkOutput("x0_mdu_ready_post", 64'(bus.mdu_ready), 64'd1);
    checkOutput("x0_mdu_we3_a",      64'(bus.we3),       64'd0);
    tick();
    checkOutput("x0_mdu_we3_b",      64'(bus.we3),       64'd0);

    $display("[TB] single MDU result for x7");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("x7_busy_set", 64'(bus.busy), 64'h80);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12);
    tick();
    idle();
    checkOutput("x7_no_bypass",  64'(bus.we3),       64'd0);
    checkOutput("x7_ready_one",  64'(bus.mdu_ready), 64'd1);
    checkOutput("x7_busy_hold",  64'(bus.busy),      64'h80);
    tick();
    checkOutput("x7_we3",        64'(bus.we3),        64'd1);
    checkOutput("x7_addr",       64'(bus.write_addr), 64'd7);
    checkOutput("x7_wd",         64'(bus.wd3),        64'h12);
    checkOutput("x7_busy_clear", 64'(bus.busy),       64'd0);
    tick();
    checkOutput("x7_we3_done",   64'(bus.we3),        64'd0);

    $display("[TB] starvation with pipeline writing every cycle");
    applyStimulus(1'b1, 5'd10, 32'h100, 1'b1, 5'd3, 1'b1, 5'd3, 32'h33);
    tick();
    checkOutput("st_t0_ready", 64'(bus.mdu_ready), 64'd1);
    applyStimulus(1'b1, 5'd10, 32'h101, 1'b1, 5'd4, 1'b1, 5'd4, 32'h44);
    tick();
    checkOutput("st_t1_ready", 64'(bus.mdu_ready), 64'd0);
    checkOutput("st_t1_busy",  64'(bus.busy),      64'h18);
    checkOutput("st_t1_addr",  64'(bus.write_addr), 64'd10);
    applyStimulus(1'b1, 5'd10, 32'h102, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("st_t2_wd",    64'(bus.wd3),        64'h102);
    checkOutput("st_t2_stall", 64'(bus.pipe_stall), 64'd0);
    applyStimulus(1'b1, 5'd10, 32'h103, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("st_t3_stall", 64'(bus.pipe_stall), 64'd0);
    applyStimulus(1'b1, 5'd10, 32'h104, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("st_t4_stall", 64'(bus.pipe_stall), 64'd1);
    checkOutput("st_t4_wd",    64'(bus.wd3),        64'h104);
    idle();
    tick();
    checkOutput("st_t5_we3",   64'(bus.we3),        64'd1);
    checkOutput("st_t5_addr",  64'(bus.write_addr), 64'd3);
    checkOutput("st_t5_wd",    64'(bus.wd3),        64'h33);
    checkOutput("st_t5_busy",  64'(bus.busy),       64'h10);
    checkOutput("st_t5_stall", 64'(bus.pipe_stall), 64'd0);
    checkOutput("st_t5_ready", 64'(bus.mdu_ready),  64'd1);
    applyStimulus(1'b1, 5'd11, 32'h200, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    tick();
    checkOutput("st_t8_stall", 64'(bus.pipe_stall), 64'd0);
    checkOutput("st_t8_addr",  64'(bus.write_addr), 64'd11);
    tick();
    checkOutput("st_t9_stall", 64'(bus.pipe_stall), 64'd1);
    idle();
    tick();
    checkOutput("st_t10_we3",  64'(bus.we3),        64'd1);
    checkOutput("st_t10_addr", 64'(bus.write_addr), 64'd4);
    checkOutput("st_t10_wd",   64'(bus.wd3),        64'h44);
    checkOutput("st_t10_busy", 64'(bus.busy),       64'd0);
    checkOutput("st_t10_stall", 64'(bus.pipe_stall), 64'd0);

    $display("[TB] issue and pop of x9 in the same cycle");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99);
    tick();
    checkOutput("x9_push_we3", 64'(bus.we3),  64'd0);
    checkOutput("x9_busy_pre", 64'(bus.busy), 64'h200);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    tick();
    idle();
    checkOutput("x9_pop_we3",  64'(bus.we3),        64'd1);
    checkOutput("x9_pop_addr", 64'(bus.write_addr), 64'd9);
    checkOutput("x9_pop_wd",   64'(bus.wd3),        64'h99);
    checkOutput("x9_busy_set_wins", 64'(bus.busy),  64'h200);

    $display("[TB] asynchronous reset with full buffer");
    applyStimulus(1'b1, 5'd10, 32'h300, 1'b1, 5'd12, 1'b1, 5'd12, 32'hC);
    tick();
    applyStimulus(1'b1, 5'd10, 32'h301, 1'b1, 5'd13, 1'b1, 5'd13, 32'hD);
    tick();
    idle();
    checkOutput("rst_pre_ready", 64'(bus.mdu_ready), 64'd0);
    checkOutput("rst_pre_busy",  64'(bus.busy),      64'h3200);
    checkOutput("rst_pre_we3",   64'(bus.we3),       64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_we3",   64'(bus.we3),        64'd0);
    checkOutput("rst_async_addr",  64'(bus.write_addr), 64'd0);
    checkOutput("rst_async_wd",    64'(bus.wd3),        64'd0);
    checkOutput("rst_async_busy",  64'(bus.busy),       64'd0);
    checkOutput("rst_async_stall", 64'(bus.pipe_stall), 64'd0);
    checkOutput("rst_async_ready", 64'(bus.mdu_ready),  64'd1);
    tick();
    rst_n = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.we3 !== 1'b0) wr_seen++;
    end
    checkOutput("rst_no_writes_after", 64'(wr_seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
